// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory (A = MEM stage, B = loader/DMA).
// Fixed priority to A with a B starvation limit; define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int B_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_stall,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    logic              a_win_s;
    logic              b_win_s;
    logic              tag_vld_q, tag_vld_d;
    logic              tag_id_q, tag_id_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

`ifdef DMEM_ARB_RR_EN
    // rr_last_q holds the id of the most recent winner
    logic rr_last_q, rr_last_d;

    // Round-robin grant: on contention the requester that did not win last goes
    always_comb begin
        a_win_s = 1'b0;
        b_win_s = 1'b0;
        if (a_req && b_req) begin
            if (rr_last_q == TAG_A) begin
                b_win_s = 1'b1;
            end else begin
                a_win_s = 1'b1;
            end
        end else begin
            a_win_s = a_req;
            b_win_s = b_req;
        end
    end

    // Pointer moves only when somebody is granted
    always_comb begin
        rr_last_d = rr_last_q;
        if (a_win_s) begin
            rr_last_d = TAG_A;
        end else if (b_win_s) begin
            rr_last_d = TAG_B;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_last_q <= TAG_A;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    localparam logic [3:0] B_MAX_WAIT_V = B_MAX_WAIT[3:0];

    logic [3:0] b_wait_q, b_wait_d;

    // Fixed-priority grant: A wins unless B has waited B_MAX_WAIT cycles in a row
    always_comb begin
        a_win_s = 1'b0;
        b_win_s = 1'b0;
        if (a_req && b_req) begin
            if (b_wait_q == B_MAX_WAIT_V) begin
                b_win_s = 1'b1;
            end else begin
                a_win_s = 1'b1;
            end
        end else begin
            a_win_s = a_req;
            b_win_s = b_req;
        end
    end

    // Saturating count of consecutive cycles B asked and lost
    always_comb begin
        b_wait_d = 4'd0;
        if (b_req && !b_win_s) begin
            if (b_wait_q == 4'hF) begin
                b_wait_d = b_wait_q;
            end else begin
                b_wait_d = b_wait_q + 4'd1;
            end
        end else begin
            b_wait_d = 4'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b_wait_q <= 4'd0;
        end else begin
            b_wait_q <= b_wait_d;
        end
    end
`endif

    // Memory bus mux; idle cycles park on A's address with writes disabled
    always_comb begin
        address_dmem = a_addr;
        data         = a_wdata;
        wren         = 1'b0;
        if (b_win_s) begin
            address_dmem = b_addr;
            data         = b_wdata;
            wren         = b_we;
        end else if (a_win_s) begin
            address_dmem = a_addr;
            data         = a_wdata;
            wren         = a_we;
        end else begin
            wren         = 1'b0;
        end
    end

    // Read-tag pipeline and response capture: tag at T, data at T+1, pulse in T+2
    always_comb begin
        tag_vld_d  = (a_win_s && !a_we) || (b_win_s && !b_we);
        tag_id_d   = b_win_s ? TAG_B : TAG_A;
        a_rvalid_d = tag_vld_q && (tag_id_q == TAG_A);
        b_rvalid_d = tag_vld_q && (tag_id_q == TAG_B);
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (a_rvalid_d) begin
            a_rdata_d = q_dmem;
        end else begin
            a_rdata_d = a_rdata_q;
        end
        if (b_rvalid_d) begin
            b_rdata_d = q_dmem;
        end else begin
            b_rdata_d = b_rdata_q;
        end
    end

    // Response pipeline registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_vld_q  <= 1'b0;
            tag_id_q   <= TAG_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt    = a_win_s;
    assign b_gnt    = b_win_s;
    assign a_stall  = a_req && !a_win_s;
    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps then random traffic, checked against a
// transaction-level reference model (grant rule, reference memory, response queue).
module tb_dmem_arbiter;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BMW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid, wren;
    logic [DW-1:0] a_rdata, b_rdata, data, q_dmem;
    logic [AW-1:0] address_dmem;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .B_MAX_WAIT(BMW)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    // Synchronous single-port memory the DUT drives
    logic [DW-1:0] dmem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clock) begin
        if (wren) dmem[address_dmem] <= data;
        q_dmem <= dmem[address_dmem];
    end

    // Reference model state
    typedef struct {int due; bit id; logic [DW-1:0] d;} resp_t;
    resp_t         rq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] last_a, last_b;
    int            b_lost;
    bit            last_win_b;
    int            cyc;
    int            checks = 0;
    int            errors = 0;
    int            bcount;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        last_a     = '0;
        last_b     = '0;
        b_lost     = 0;
        last_win_b = 1'b0;
    endtask

    task automatic set_a(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = wd;
    endtask

    // One cycle: check against the model at negedge, advance the model, return at posedge+1
    task automatic tick();
        bit            ea, eb, exp_av, exp_bv;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        bit            exp_wren;
        resp_t         r;
        @(negedge clock);
        if (a_req && b_req) begin
`ifdef DMEM_ARB_RR_EN
            eb = !last_win_b;
`else
            eb = (b_lost == BMW);
`endif
            ea = !eb;
        end else begin
            ea = a_req;
            eb = b_req;
        end
        exp_addr = eb ? b_addr  : a_addr;
        exp_data = eb ? b_wdata : a_wdata;
        exp_wren = eb ? b_we : (ea ? a_we : 1'b0);
        exp_av = 1'b0;
        exp_bv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.id) begin exp_bv = 1'b1; last_b = r.d; end
            else      begin exp_av = 1'b1; last_a = r.d; end
        end
        chk("a_gnt",    DW'(a_gnt),        DW'(ea));
        chk("b_gnt",    DW'(b_gnt),        DW'(eb));
        chk("a_stall",  DW'(a_stall),      DW'(a_req && !ea));
        chk("wren",     DW'(wren),         DW'(exp_wren));
        chk("address",  DW'(address_dmem), DW'(exp_addr));
        chk("data",     data,              exp_data);
        chk("a_rvalid", DW'(a_rvalid),     DW'(exp_av));
        chk("b_rvalid", DW'(b_rvalid),     DW'(exp_bv));
        chk("a_rdata",  a_rdata,           last_a);
        chk("b_rdata",  b_rdata,           last_b);
        if (b_gnt) bcount++;
        if (ea) begin
            if (a_we) ref_mem[a_addr] = a_wdata;
            else      rq.push_back('{cyc + 2, 1'b0, ref_mem[a_addr]});
            last_win_b = 1'b0;
        end
        if (eb) begin
            if (b_we) ref_mem[b_addr] = b_wdata;
            else      rq.push_back('{cyc + 2, 1'b1, ref_mem[b_addr]});
            last_win_b = 1'b1;
        end
        b_lost = (b_req && !eb) ? ((b_lost < 15) ? b_lost + 1 : 15) : 0;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        set_a(1'b0, 1'b0, 0, '0);
        set_b(1'b0, 1'b0, 0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        cyc = 0;
        bcount = 0;
        model_reset();
        set_a(1'b1, 1'b0, 'h010, '0);
        set_b(1'b0, 1'b0, 0, '0);

        // Held in reset with A requesting: outputs stay cleared
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_a_rvalid", DW'(a_rvalid), '0);
            chk("rst_b_rvalid", DW'(b_rvalid), '0);
            chk("rst_a_rdata",  a_rdata,       '0);
            chk("rst_b_rdata",  b_rdata,       '0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        idle(3);

        // B preloads 0x010, then A reads it back
        set_b(1'b1, 1'b1, 'h010, 32'hDEADBEEF);
        tick();
        set_b(1'b0, 1'b0, 0, '0);
        set_a(1'b1, 1'b0, 'h010, '0);
        tick();
        idle(3);
        chk("preload_read", a_rdata, 32'hDEADBEEF);

        // B write followed next cycle by A read of the same word
        set_b(1'b1, 1'b1, 'h020, 32'h12345678);
        tick();
        set_b(1'b0, 1'b0, 0, '0);
        set_a(1'b1, 1'b0, 'h020, '0);
        tick();
        idle(3);
        chk("raw_read", a_rdata, 32'h12345678);

        // Continuous contention: count B grants over ten cycles
        bcount = 0;
        for (int i = 0; i < 10; i++) begin
            set_a(1'b1, 1'b0, 'h010, '0);
            set_b(1'b1, 1'b0, 'h020 + i, '0);
            tick();
        end
`ifdef DMEM_ARB_RR_EN
        chk("b_gnt_count", DW'(bcount), 32'd5);
`else
        chk("b_gnt_count", DW'(bcount), 32'd2);
`endif
        idle(3);

        // A read in flight when reset hits: no response afterwards
        set_a(1'b1, 1'b0, 'h010, '0);
        tick();
        set_a(1'b0, 1'b0, 0, '0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk("midrst_a_rvalid", DW'(a_rvalid), '0);
        chk("midrst_a_rdata",  a_rdata,       '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(3);

        // Random mixed traffic over a small address window
        for (int i = 0; i < 500; i++) begin
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom);
            set_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom);
            tick();
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
